fft_peak_detect: RTL and testbench
==================================

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter NFFT, default 512: bins per frame.
REQ-002 SHALL have parameter MIN_BIN, default 1: lowest bin included in the search.
REQ-003 SHALL have parameter MAX_BIN, default 255: highest bin included in the search (MIN_BIN <= MAX_BIN < NFFT).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port s_tdata, input, 32 bits: FFT output sample; [15:0] real part, [31:16] imaginary part, both signed two's complement.
REQ-007 SHALL have port s_tvalid, input, 1 bit: the FFT output sample on s_tdata is valid.
REQ-008 SHALL have port s_tready, output, 1 bit: the block can accept a sample.
REQ-009 SHALL have port s_tlast, input, 1 bit: marks the last bin of a frame.
REQ-010 SHALL have port m_valid, output, 1 bit: a result is pending.
REQ-011 SHALL have port m_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port peak_bin, output, 9 bits: index of the maximum-magnitude bin.
REQ-013 SHALL have port peak_mag, output, 33 bits: unsigned re^2+im^2 of that bin.
REQ-014 SHALL have port frame_err, output, 1 bit: the completed frame length was not NFFT.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag, set when a pending result was overwritten.

Function
REQ-016 SHALL accept a beat only when s_tvalid and s_tready are both 1.
REQ-017 SHALL keep a 9-bit bin counter: increment on each accepted beat, return to 0 after the beat carrying s_tlast or after bin NFFT-1, whichever comes first.
REQ-018 SHALL register the full-width products re*re and im*im (each 32 bits) one cycle after acceptance (stage 1).
REQ-019 SHALL form the 33-bit unsigned sum in stage 2 and compare it against the running maximum.
REQ-020 SHALL update the running maximum and its bin only for bins in [MIN_BIN, MAX_BIN] whose magnitude is strictly greater; on a tie the lowest bin wins.
REQ-021 SHALL reset the running maximum to 0 and its bin to MIN_BIN at frame start; a frame containing only zeros reports bin MIN_BIN with magnitude 0.
REQ-022 SHALL treat the frame-closing beat (s_tlast, or counter = NFFT-1) accepted at cycle T as follows: load peak_bin, peak_mag and frame_err and assert m_valid at the rising edge T+3.
REQ-023 SHALL set frame_err = 1 when s_tlast arrives at a count other than NFFT-1, or when count NFFT-1 arrives without s_tlast; the result is still reported, and the counter resyncs to 0.
REQ-024 SHALL hold m_valid and its outputs stable until the m_valid && m_ready handshake; m_valid drops the cycle after that handshake unless a new result loads in the same cycle.
REQ-025 SHALL, when a new result loads in the same cycle as the handshake, show the new result and keep m_valid at 1 without setting overrun.
REQ-026 SHALL support back-to-back frames with no idle cycles; the pipeline holds no per-frame dead time.
REQ-027 SHALL stall the stage 1 and stage 2 pipeline with the input: a beat advances only when accepted.

Reset
REQ-028 SHALL, while reset_n = 0, force: s_tready = 0, m_valid = 0, peak_bin = 0, peak_mag = 0, frame_err = 0, overrun = 0, bin counter = 0, pipeline valids = 0.
REQ-029 SHALL, on reset mid-frame, discard the partial frame; the first beat after release is bin 0.
REQ-030 SHALL drive s_tready = 1 in the first cycle after reset_n deasserts (subject to REQ-031).

Configuration
REQ-031 SHALL, when macro FPD_BACKPRESSURE_EN is defined, drive s_tready = !(m_valid && !m_ready) so an unread result stalls input and overrun never sets.
REQ-032 SHALL, when FPD_BACKPRESSURE_EN is undefined, drive s_tready = 1 after reset; a new result overwrites an unread one and sets overrun, which stays set until reset.

Verification
REQ-033 SHALL cover: one 512-beat frame with all bins 0 except bin 40 = (re 100, im -50) -> peak_bin 40, peak_mag 12500, frame_err 0, m_valid asserted 3 cycles after the tlast beat.
REQ-034 SHALL cover: equal magnitude 0x4000_0000 (re=-32768, im=0) at bins 10 and 20 -> peak_bin 10, peak_mag 1073741824.
REQ-035 SHALL cover: bin 0 = 30000 and bin 300 = 30000 (outside 1..255), bin 5 = 3 -> peak_bin 5, peak_mag 9.
REQ-036 SHALL cover: tlast on beat index 99 -> frame_err 1; the next 512-beat frame reports frame_err 0 with the correct peak.
REQ-037 SHALL cover: two frames with m_ready held 0 -> with the macro defined, s_tready = 0 after the first result and overrun = 0; with it undefined, the second result is shown and overrun = 1.
REQ-038 SHALL cover: reset_n pulsed low at beat 200 -> all outputs are 0 during reset, and a following full frame reports the correct peak.

Source files
------------

// File: rtl/fft_peak_detect.sv
// Per-frame peak finder for a streaming FFT: tracks the largest re^2+im^2 bin in [MIN_BIN, MAX_BIN].
// Optional macro FPD_BACKPRESSURE_EN: an unread result stalls the input instead of being overwritten.
module fft_peak_detect #(
   parameter int NFFT    = 512,
   parameter int MIN_BIN = 1,
   parameter int MAX_BIN = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [8:0]  peak_bin,
   output logic [32:0] peak_mag,
   output logic        frame_err,
   output logic        overrun
);

   localparam logic [8:0] LAST_BIN = 9'(NFFT - 1);
   localparam logic [8:0] LO_BIN   = 9'(MIN_BIN);
   localparam logic [8:0] HI_BIN   = 9'(MAX_BIN);

   logic        ready_q;
   logic        accept;
   logic [8:0]  cnt_q, cnt_d;
   logic        at_end, close, len_err;

   logic signed [31:0] re_s, im_s;
   logic [31:0] re_sq, im_sq;

   logic        s1_vld_q, s1_last_q, s1_err_q;
   logic [8:0]  s1_bin_q;
   logic [31:0] s1_re2_q, s1_im2_q;

   logic        s2_vld_q, s2_last_q, s2_err_q;
   logic [8:0]  s2_bin_q;
   logic [32:0] s2_mag_q;

   logic [32:0] max_q, max_d;
   logic [8:0]  max_bin_q, max_bin_d;
   logic        res_vld_q, res_vld_d;
   logic [32:0] res_mag_q, res_mag_d;
   logic [8:0]  res_bin_q, res_bin_d;
   logic        res_err_q, res_err_d;

   logic        mval_q, mval_d;
   logic [8:0]  pbin_q, pbin_d;
   logic [32:0] pmag_q, pmag_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;

   logic        in_range, better;
   logic [32:0] best_mag;
   logic [8:0]  best_bin;

`ifdef FPD_BACKPRESSURE_EN
   assign s_tready = ready_q && !(mval_q && !m_ready);
`else
   assign s_tready = ready_q;
`endif

   assign accept  = s_tvalid && s_tready;
   assign at_end  = (cnt_q == LAST_BIN);
   assign close   = s_tlast || at_end;
   // A frame is well-formed only when tlast and the final count coincide.
   assign len_err = s_tlast ^ at_end;
   assign cnt_d   = accept ? (close ? 9'd0 : cnt_q + 9'd1) : cnt_q;

   assign re_s  = {{16{s_tdata[15]}}, s_tdata[15:0]};
   assign im_s  = {{16{s_tdata[31]}}, s_tdata[31:16]};
   assign re_sq = re_s * re_s;
   assign im_sq = im_s * im_s;

   assign in_range = (s2_bin_q >= LO_BIN) && (s2_bin_q <= HI_BIN);
   assign better   = s2_vld_q && in_range && (s2_mag_q > max_q);
   assign best_mag = better ? s2_mag_q : max_q;
   assign best_bin = better ? s2_bin_q : max_bin_q;

   // The closing beat hands its final peak to the result register and re-arms the search.
   always_comb begin
      max_d     = max_q;
      max_bin_d = max_bin_q;
      res_vld_d = 1'b0;
      res_mag_d = res_mag_q;
      res_bin_d = res_bin_q;
      res_err_d = res_err_q;
      if (s2_vld_q) begin
         if (s2_last_q) begin
            res_vld_d = 1'b1;
            res_mag_d = best_mag;
            res_bin_d = best_bin;
            res_err_d = s2_err_q;
            max_d     = 33'd0;
            max_bin_d = LO_BIN;
         end else begin
            max_d     = best_mag;
            max_bin_d = best_bin;
         end
      end
   end

   always_comb begin
      mval_d = mval_q && !m_ready;
      pbin_d = pbin_q;
      pmag_d = pmag_q;
      ferr_d = ferr_q;
      ovr_d  = ovr_q;
      if (res_vld_q) begin
         mval_d = 1'b1;
         pbin_d = res_bin_q;
         pmag_d = res_mag_q;
         ferr_d = res_err_q;
         if (mval_q && !m_ready) ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_q   <= 1'b0;
         cnt_q     <= 9'd0;
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_err_q  <= 1'b0;
         s1_bin_q  <= 9'd0;
         s1_re2_q  <= 32'd0;
         s1_im2_q  <= 32'd0;
         s2_vld_q  <= 1'b0;
         s2_last_q <= 1'b0;
         s2_err_q  <= 1'b0;
         s2_bin_q  <= 9'd0;
         s2_mag_q  <= 33'd0;
         max_q     <= 33'd0;
         max_bin_q <= LO_BIN;
         res_vld_q <= 1'b0;
         res_mag_q <= 33'd0;
         res_bin_q <= 9'd0;
         res_err_q <= 1'b0;
         mval_q    <= 1'b0;
         pbin_q    <= 9'd0;
         pmag_q    <= 33'd0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         ready_q   <= 1'b1;
         cnt_q     <= cnt_d;
         s1_vld_q  <= accept;
         if (accept) begin
            s1_last_q <= close;
            s1_err_q  <= len_err;
            s1_bin_q  <= cnt_q;
            s1_re2_q  <= re_sq;
            s1_im2_q  <= im_sq;
         end
         s2_vld_q  <= s1_vld_q;
         if (s1_vld_q) begin
            s2_last_q <= s1_last_q;
            s2_err_q  <= s1_err_q;
            s2_bin_q  <= s1_bin_q;
            s2_mag_q  <= {1'b0, s1_re2_q} + {1'b0, s1_im2_q};
         end
         max_q     <= max_d;
         max_bin_q <= max_bin_d;
         res_vld_q <= res_vld_d;
         res_mag_q <= res_mag_d;
         res_bin_q <= res_bin_d;
         res_err_q <= res_err_d;
         mval_q    <= mval_d;
         pbin_q    <= pbin_d;
         pmag_q    <= pmag_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign m_valid   = mval_q;
   assign peak_bin  = pbin_q;
   assign peak_mag  = pmag_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect: directed and randomized frames against a per-frame peak model.
// Build with or without FPD_BACKPRESSURE_EN; the overrun step adapts to the macro.
module tb_fft_peak_detect;
   localparam int NFFT    = 512;
   localparam int MIN_BIN = 1;
   localparam int MAX_BIN = 255;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [8:0]  peak_bin;
   logic [32:0] peak_mag;
   logic        frame_err;
   logic        overrun;

   fft_peak_detect #(.NFFT(NFFT), .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .m_valid(m_valid), .m_ready(m_ready),
      .peak_bin(peak_bin), .peak_mag(peak_mag), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int fre[NFFT];
   int fim[NFFT];
   // {frame_err, peak_bin, peak_mag}
   logic [42:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clear_frame();
      for (int i = 0; i < NFFT; i++) begin
         fre[i] = 0;
         fim[i] = 0;
      end
   endtask

   task automatic rand_frame(input int span);
      for (int i = 0; i < NFFT; i++) begin
         fre[i] = int'($urandom_range(2 * span)) - span;
         fim[i] = int'($urandom_range(2 * span)) - span;
      end
   endtask

   // Peak = first bin in the search window holding the largest re^2+im^2.
   function automatic logic [42:0] model(input int len, input bit with_last);
      longint best = 0;
      longint m;
      int bin = MIN_BIN;
      bit err;
      for (int b = MIN_BIN; b <= MAX_BIN && b < len; b++) begin
         m = longint'(fre[b]) * fre[b] + longint'(fim[b]) * fim[b];
         if (m > best) begin
            best = m;
            bin = b;
         end
      end
      err = !(len == NFFT && with_last);
      return {err, 9'(bin), 33'(best)};
   endfunction

   task automatic send_beats(input int len, input bit with_last);
      int guard;
      for (int i = 0; i < len; i++) begin
         s_tdata  = {16'(fim[i]), 16'(fre[i])};
         s_tvalid = 1'b1;
         s_tlast  = with_last && (i == len - 1);
         guard = 0;
         while (!s_tready && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
         end
         if (guard >= 2000) chk("ready_wait", 64'(s_tready), 64'd1);
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int len, input bit with_last);
      exp_q.push_back(model(len, with_last));
      send_beats(len, with_last);
   endtask

   // Called just after the closing beat's edge T; the result must land exactly at T+3.
   task automatic expect_result(input bit idle_before);
      logic [42:0] e;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (idle_before) chk("m_valid_early", 64'(m_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("m_valid_t3", 64'(m_valid), 64'd1);
      chk("peak_bin", 64'(peak_bin), 64'(e[41:33]));
      chk("peak_mag", 64'(peak_mag), 64'(e[32:0]));
      chk("frame_err", 64'(frame_err), 64'(e[42]));
   endtask

   task automatic consume();
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      chk("m_valid_drop", 64'(m_valid), 64'd0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_peak_bin", 64'(peak_bin), 64'd0);
      chk("rst_peak_mag", 64'(peak_mag), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c1, c2;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_reset", 64'(s_tready), 64'd1);

      // Single peak at bin 40, checked at exactly T+3
      clear_frame();
      fre[40] = 100;
      fim[40] = -50;
      send_frame(NFFT, 1'b1);
      expect_result(1'b1);
      consume();
      chk("overrun_clear", 64'(overrun), 64'd0);

      // Tie at 10 and 20 -> lower bin wins
      clear_frame();
      fre[10] = -32768;
      fre[20] = -32768;
      send_frame(NFFT, 1'b1);
      expect_result(1'b1);
      consume();

      // Large values outside the window are ignored
      clear_frame();
      fre[0] = 30000;
      fre[300] = 30000;
      fre[5] = 3;
      send_frame(NFFT, 1'b1);
      expect_result(1'b1);
      consume();

      // All-zero frame reports MIN_BIN with magnitude 0
      clear_frame();
      send_frame(NFFT, 1'b1);
      expect_result(1'b1);
      consume();

      // Short frame (tlast on beat 99), then a good frame
      rand_frame(1000);
      send_frame(100, 1'b1);
      expect_result(1'b1);
      consume();
      rand_frame(32767);
      send_frame(NFFT, 1'b1);
      expect_result(1'b1);
      consume();

      // Full count without tlast is an error; counter resyncs for the next frame
      rand_frame(5000);
      send_frame(NFFT, 1'b0);
      expect_result(1'b1);
      consume();
      rand_frame(5000);
      send_frame(NFFT, 1'b1);
      expect_result(1'b1);
      consume();

      // Randomized frames, some with a forced tie
      for (int k = 0; k < 4; k++) begin
         rand_frame((k == 0) ? 300 : 32767);
         if (k % 2 == 1) begin
            c1 = int'($urandom_range(MIN_BIN, 120));
            c2 = c1 + int'($urandom_range(1, 100));
            fre[c1] = -32768;
            fim[c1] = -32768;
            fre[c2] = -32768;
            fim[c2] = -32768;
         end
         send_frame(NFFT, 1'b1);
         expect_result(1'b1);
         consume();
      end

      // Back-to-back frames with no idle cycle between them
      rand_frame(20000);
      send_frame(NFFT, 1'b1);
      rand_frame(20000);
      fork
         send_frame(NFFT, 1'b1);
         begin
            expect_result(1'b1);
            consume();
         end
      join
      expect_result(1'b1);
      consume();

      // Two frames with m_ready held low
      rand_frame(1000);
      fre[30] = 20000;
      send_frame(NFFT, 1'b1);
      rand_frame(1000);
      fre[31] = 25000;
`ifdef FPD_BACKPRESSURE_EN
      fork
         send_frame(NFFT, 1'b1);
         begin
            expect_result(1'b1);
            repeat (5) @(posedge clk);
            #1;
            chk("bp_s_tready", 64'(s_tready), 64'd0);
            chk("bp_m_valid", 64'(m_valid), 64'd1);
            chk("bp_overrun", 64'(overrun), 64'd0);
            consume();
         end
      join
      expect_result(1'b1);
      consume();
      chk("bp_overrun_end", 64'(overrun), 64'd0);
`else
      send_frame(NFFT, 1'b1);
      void'(exp_q.pop_front());
      expect_result(1'b0);
      chk("ovr_set", 64'(overrun), 64'd1);
      consume();
      chk("ovr_sticky", 64'(overrun), 64'd1);
`endif

      // Reset in the middle of a frame
      rand_frame(32767);
      send_beats(200, 1'b0);
      reset_n = 1'b0;
      #2;
      check_reset_outputs();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_reset2", 64'(s_tready), 64'd1);
      rand_frame(10000);
      fre[77] = -32768;
      send_frame(NFFT, 1'b1);
      expect_result(1'b1);
      consume();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
